// File: rtl/sram_1r1w_client_ctrl.sv
// Client controller for a 1R1W masked SRAM macro: zero-fills the array after reset,
// then serves in-order read/write requests and returns read data through a 2-entry response FIFO.
module sram_1r1w_client_ctrl #(
    parameter int unsigned          ADDR_W   = 9,
    parameter int unsigned          DATA_W   = 12,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_r_en,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_w_addr,
    output logic [DATA_W-1:0] sram_w_data,
    output logic              sram_w_mask
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fill_ptr;
    logic              inflight;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              filling;
    logic              rd_acc;
    logic              wr_acc;
    logic              push;
    logic              pop;
    logic              read_ok;
    logic [2:0]        occupancy;

    // Handshake: a request transfers in a cycle where req_valid & req_ready; a response
    // transfers where resp_valid & resp_ready. Neither side may retract valid before transfer.
    always_comb begin
        state_nxt   = state;
        filling     = 1'b0;
        req_ready   = 1'b0;
        rd_acc      = 1'b0;
        wr_acc      = 1'b0;
        sram_r_en   = 1'b0;
        sram_r_addr = '0;
        sram_w_en   = 1'b0;
        sram_w_addr = '0;
        sram_w_data = '0;
        sram_w_mask = 1'b0;

        resp_valid = (count != 2'd0);
        pop        = resp_valid & resp_ready;
        push       = inflight;
        // Slots already promised: queued entries plus the read in flight, minus the one leaving now.
        occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        read_ok    = (occupancy < 3'd2);

        case (state)
            ST_INIT: begin
                // Held-reset cycles drive nothing so the macro sees a quiet interface.
                filling = reset_n;
                if (fill_ptr == {ADDR_W{1'b1}}) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                req_ready = req_write | read_ok;
                wr_acc    = req_valid & req_ready & req_write;
                rd_acc    = req_valid & req_ready & ~req_write;
            end
            default: state_nxt = ST_INIT;
        endcase

        if (filling) begin
            sram_w_en   = 1'b1;
            sram_w_addr = fill_ptr;
            sram_w_data = INIT_VAL;
            sram_w_mask = 1'b1;
        end else if (wr_acc) begin
            sram_w_en   = 1'b1;
            sram_w_addr = req_addr;
            sram_w_data = req_wdata;
            sram_w_mask = req_wmask;
        end

        if (rd_acc) begin
            sram_r_en   = 1'b1;
            sram_r_addr = req_addr;
        end
    end

    assign init_done = (state == ST_RUN);
    assign resp_data = resp_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            fill_ptr <= '0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_acc;
            if (filling) fill_ptr <= fill_ptr + ADDR_W'(1);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clock) begin
        if (reset_n && push) fifo_mem[wr_ptr] <= sram_r_data;
    end

    no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (count == 2'd2) && !pop));

endmodule

// File: tb/tb_sram_1r1w_client_ctrl.sv
// Bench for sram_1r1w_client_ctrl: behavioural macro model, array reference model,
// directed scenarios plus randomized traffic, with a queue-based response scoreboard.
module tb_sram_1r1w_client_ctrl;
    localparam int AW    = 9;
    localparam int DW    = 12;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_wmask;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          init_done;
    logic          sram_r_en;
    logic [AW-1:0] sram_r_addr;
    logic [DW-1:0] sram_r_data;
    logic          sram_w_en;
    logic [AW-1:0] sram_w_addr;
    logic [DW-1:0] sram_w_data;
    logic          sram_w_mask;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] mac_mem [DEPTH];
    logic [DW-1:0] mac_rdata;
    bit            rr_random = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    sram_1r1w_client_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .init_done(init_done),
        .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
        .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data),
        .sram_w_mask(sram_w_mask)
    );

    // clock / reset block
    always #5 clock = ~clock;

    // Macro: registered read address, read captures the pre-write contents.
    assign sram_r_data = mac_rdata;
    always @(posedge clock) begin
        if (sram_r_en) mac_rdata <= mac_mem[sram_r_addr];
        if (sram_w_en && sram_w_mask) mac_mem[sram_w_addr] <= sram_w_data;
    end

    always @(posedge clock) begin
        #1;
        if (rr_random) resp_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Driver: present one request and hold it until accepted; update the reference on acceptance.
    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic m);
        int n = 0;
        bit acc = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
        while (!acc && n < 200) begin
            @(negedge clock);
            if (req_ready) begin
                acc = 1'b1;
                if (w) begin
                    check("w_en", sram_w_en, 1);
                    check("w_addr", sram_w_addr, a);
                    check("w_data", sram_w_data, d);
                    check("w_mask", sram_w_mask, m);
                    if (m) ref_mem[a] = d;
                end else begin
                    check("r_en", sram_r_en, 1);
                    check("r_addr", sram_r_addr, a);
                    exp_q.push_back(ref_mem[a]);
                end
            end
            @(posedge clock); #1;
            n++;
        end
        req_valid = 1'b0;
        check("req_accepted", acc, 1);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check("idle_w_en", sram_w_en, 0);
            check("idle_r_en", sram_r_en, 0);
            @(posedge clock); #1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        logic [DW-1:0] e;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", resp_valid, 1);
                check("hold_data", resp_data, prev_data);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got=%0h expected=no response", resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", resp_data, e);
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_data  = resp_data;
        end
    end

    initial begin
        int n;
        int nxt;
        bit acc;
        for (int i = 0; i < DEPTH; i++) mac_mem[i] <= DW'($urandom);
        clear_ref();
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = 1'b0; resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_w_en", sram_w_en, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_init_done", init_done, 0);
        @(posedge clock); #1;

        // Scenario 1: read held from reset release, stalls for the whole fill.
        reset_n = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(9'h1FF);
        n = 0; acc = 1'b0;
        while (!acc && n < 1000) begin
            @(negedge clock);
            if (req_ready) begin
                acc = 1'b1;
                check("init_done_high", init_done, 1);
                exp_q.push_back(ref_mem[9'h1FF]);
            end else begin
                check("init_w_en", sram_w_en, 1);
                check("init_w_addr", sram_w_addr, n);
                check("init_r_en", sram_r_en, 0);
                check("init_done_low", init_done, 0);
                n++;
            end
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        check("init_accept", acc, 1);
        check("init_cycles", n, DEPTH);
        idle(3);

        // Scenario 2: write then read, checking 2-cycle response latency.
        do_req(1'b1, 9'h01F, 12'h5A3, 1'b1);
        do_req(1'b0, 9'h01F, '0, 1'b0);
        @(negedge clock);
        check("lat_cycle1", resp_valid, 0);
        @(negedge clock);
        check("lat_cycle2", resp_valid, 1);
        @(posedge clock); #1;
        idle(2);

        // Scenario 3: masked-off write leaves data intact.
        do_req(1'b1, 9'h040, 12'h777, 1'b1);
        do_req(1'b1, 9'h040, 12'h123, 1'b0);
        do_req(1'b0, 9'h040, '0, 1'b0);
        idle(3);

        // Scenario 4: backpressure fills the FIFO, then drains in order.
        for (int i = 0; i < 4; i++) do_req(1'b1, AW'(i), DW'(12'hA00 + i), 1'b1);
        resp_ready = 1'b0;
        nxt = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(nxt & 3);
            @(negedge clock);
            if (req_ready) begin
                exp_q.push_back(ref_mem[nxt & 3]);
                nxt++;
            end
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("bp_accepted", nxt, 2);
        check("bp_req_ready", req_ready, 0);
        check("bp_resp_valid", resp_valid, 1);
        check("bp_resp_data", resp_data, 12'hA00);
        @(posedge clock); #1;
        resp_ready = 1'b1;
        do_req(1'b0, 9'h002, '0, 1'b0);
        do_req(1'b0, 9'h003, '0, 1'b0);
        drain("bp_drain");

        // Scenario 5: write right after a read does not disturb that read.
        do_req(1'b1, 9'h010, 12'h111, 1'b1);
        idle(1);
        do_req(1'b0, 9'h010, '0, 1'b0);
        do_req(1'b1, 9'h010, 12'h222, 1'b1);
        do_req(1'b0, 9'h010, '0, 1'b0);
        drain("wr_after_rd_drain");

        // Randomized traffic on a small address window with random response backpressure.
        rr_random = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 1) == 1)
                do_req(1'b1, AW'($urandom_range(0, 15)), DW'($urandom), 1'($urandom_range(0, 3) != 0));
            else
                do_req(1'b0, AW'($urandom_range(0, 15)), '0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rr_random = 1'b0;
        @(posedge clock); #2;
        resp_ready = 1'b1;
        drain("rand_drain");

        // Scenario 6: reset with two queued responses.
        resp_ready = 1'b0;
        do_req(1'b1, 9'h005, 12'hBEE, 1'b1);
        do_req(1'b0, 9'h005, '0, 1'b0);
        do_req(1'b0, 9'h006, '0, 1'b0);
        idle(3);
        @(negedge clock);
        check("pre_rst_valid", resp_valid, 1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        exp_q.delete();
        clear_ref();
        @(negedge clock);
        check("rst2_resp_valid", resp_valid, 0);
        check("rst2_init_done", init_done, 0);
        check("rst2_w_en", sram_w_en, 1);
        check("rst2_w_addr", sram_w_addr, 0);
        resp_ready = 1'b1;
        n = 0;
        while (!init_done && n < 600) begin
            @(negedge clock);
            n++;
        end
        check("rst2_refill", init_done, 1);
        @(posedge clock); #1;
        do_req(1'b0, 9'h005, '0, 1'b0);
        do_req(1'b0, 9'h1FF, '0, 1'b0);
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
